cpu_controller: RTL

- Instruction-sequencing state machine for the 8-bit accumulator CPU.
- Each instruction executes in an eight-step cycle. The controller drives the strobes for the following blocks:
  - program counter
  - instruction register
  - data bus driver
  - memory read/write
  - ALU enable (con_alu)
  - accumulator load
- It sits directly upstream of the ALU. It consumes the ALU's zero flag and the IR opcode, and decides when alu_out is computed and when the accumulator captures it.

---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/cpu_controller.sv | 126 ++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, controller states and strobe bundle.
package cpu_pkg;

    localparam logic [2:0] OpHlt = 3'b000;
    localparam logic [2:0] OpSkz = 3'b001;
    localparam logic [2:0] OpAdd = 3'b010;
    localparam logic [2:0] OpAnd = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpLda = 3'b101;
    localparam logic [2:0] OpSto = 3'b110;
    localparam logic [2:0] OpJmp = 3'b111;

    typedef enum logic [3:0] {
        St0      = 4'd0,
        St1      = 4'd1,
        St2      = 4'd2,
        St3      = 4'd3,
        St4      = 4'd4,
        St5      = 4'd5,
        St6      = 4'd6,
        St7      = 4'd7,
        StIdle   = 4'd8,
        StHalted = 4'd9
    } state_e;

    typedef struct packed {
        logic inc_pc;
        logic load_pc;
        logic load_ir;
        logic rd;
        logic wr;
        logic datactl_ena;
        logic con_alu;
        logic load_acc;
        logic halt;
    } ctl_t;

    // Opcodes that read an operand from memory and write the accumulator.
    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OpAdd) || (op == OpAnd) || (op == OpXor) || (op == OpLda);
    endfunction

endpackage

// File: rtl/cpu_controller.sv
// Eight-step instruction sequencer. Strobes are decoded for the state being entered and
// registered, so they are valid for the whole cycle of that state.
module cpu_controller
    import cpu_pkg::*;
#(
    parameter bit HaltSticky = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ena_i,
    input  logic [2:0] opcode_i,
    input  logic       zero_i,
    output logic       inc_pc_o,
    output logic       load_pc_o,
    output logic       load_ir_o,
    output logic       rd_o,
    output logic       wr_o,
    output logic       datactl_ena_o,
    output logic       con_alu_o,
    output logic       load_acc_o,
    output logic       halt_o,
    output logic [3:0] state_o
);

    state_e state_q, state_d;
    ctl_t   ctl_q, ctl_d;

    always_comb begin
        state_d = state_q;
        ctl_d   = '0;
        case (state_q)
            StIdle: begin
                if (ena_i) begin
                    state_d       = St0;
                    ctl_d.rd      = 1'b1;
                    ctl_d.load_ir = 1'b1;
                end
            end
            St0: begin
                state_d       = St1;
                ctl_d.rd      = 1'b1;
                ctl_d.load_ir = 1'b1;
                ctl_d.inc_pc  = 1'b1;
            end
            St1: state_d = St2;
            St2: begin
                state_d      = St3;
                ctl_d.inc_pc = 1'b1;
                ctl_d.halt   = (opcode_i == OpHlt);
            end
            St3: begin
                if (HaltSticky && (opcode_i == OpHlt)) begin
                    state_d    = StHalted;
                    ctl_d.halt = 1'b1;
                end else begin
                    state_d = St4;
                    if (is_alu_op(opcode_i)) ctl_d.rd = 1'b1;
                    if (opcode_i == OpSto)   ctl_d.datactl_ena = 1'b1;
                    if (opcode_i == OpJmp)   ctl_d.load_pc = 1'b1;
                end
            end
            St4: begin
                state_d = St5;
                if (is_alu_op(opcode_i)) begin
                    ctl_d.rd      = 1'b1;
                    ctl_d.con_alu = 1'b1;
                end
                if (opcode_i == OpSto) begin
                    ctl_d.datactl_ena = 1'b1;
                    ctl_d.con_alu     = 1'b1;
                end
                if (opcode_i == OpJmp) begin
                    ctl_d.load_pc = 1'b1;
                    ctl_d.inc_pc  = 1'b1;
                end
                if ((opcode_i == OpSkz) && zero_i) ctl_d.inc_pc = 1'b1;
            end
            St5: begin
                state_d = St6;
                if (is_alu_op(opcode_i)) ctl_d.load_acc = 1'b1;
                if (opcode_i == OpSto) begin
                    ctl_d.wr          = 1'b1;
                    ctl_d.datactl_ena = 1'b1;
                end
            end
            St6: begin
                state_d = St7;
                // Second half of the skip: zero is re-sampled here on purpose.
                if ((opcode_i == OpSkz) && zero_i) ctl_d.inc_pc = 1'b1;
            end
            St7: begin
                if (ena_i) begin
                    state_d       = St0;
                    ctl_d.rd      = 1'b1;
                    ctl_d.load_ir = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            StHalted: ctl_d.halt = 1'b1;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_d;
        end
    end

    assign inc_pc_o      = ctl_q.inc_pc;
    assign load_pc_o     = ctl_q.load_pc;
    assign load_ir_o     = ctl_q.load_ir;
    assign rd_o          = ctl_q.rd;
    assign wr_o          = ctl_q.wr;
    assign datactl_ena_o = ctl_q.datactl_ena;
    assign con_alu_o     = ctl_q.con_alu;
    assign load_acc_o    = ctl_q.load_acc;
    assign halt_o        = ctl_q.halt;
    assign state_o       = state_q;

endmodule
